display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Next-generation multiplexed seven-segment driver. Supersedes the fixed 4-anode, derived-clock display driver.
- Scans NUM_DIGITS common-anode digits from a packed hex/BCD word using a single-clock design: a clock-enable tick, with no generated clocks.
- Adds per-digit blink mask, per-digit decimal-point mask, leading-zero blanking, anti-ghosting blank interval and tear-free frame latching.
- Sits between the stopwatch/timer datapath and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- CLK_FREQ_HZ, 100_000_000, board clock frequency.
- REFRESH_HZ, 500, full-frame refresh rate.
- BLINK_HZ, 2, blink rate; the visible/hidden phase toggles every CLK_FREQ_HZ/(2*BLINK_HZ) cycles.
- GHOST_CYCLES, 64, cycles all anodes are held off after each digit change; must be < CYCLES_PER_DIGIT.
- Derived localparam CYCLES_PER_DIGIT = CLK_FREQ_HZ/REFRESH_HZ/NUM_DIGITS; must be >= 2.

Ports:
- clk  in  1  board clock.
- rst  in  1  synchronous, active-high reset.
- number  in  4*NUM_DIGITS  packed digits; digit k = number[4k+3:4k]; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  bit k=1 lights the decimal point of digit k.
- blink_mask  in  NUM_DIGITS  bit k=1 makes digit k (segments and dp) blink.
- lzb_en  in  1  leading-zero blanking enable.
- io_sel  out  NUM_DIGITS  anode enables, active-low; bit k drives digit k.
- io_seg  out  8  segments, active-low; [6:0]=g..a, [7]=dp.
- frame_start  out  1  one-cycle pulse when digit 0 becomes selected.

Behaviour:
- Reset values: io_sel all 1, io_seg 8'hFF, frame_start 0, scan index 0, both counters 0, blink phase = visible. Reset applies whenever rst is high, including mid-frame or mid-ghost; no partial state survives.
- Tick counter counts 0..CYCLES_PER_DIGIT-1 and wraps. Terminal count is the tick.
- On a tick, the index advances k -> k+1, with NUM_DIGITS-1 -> 0. With NUM_DIGITS=1 the index stays 0 and ticks still occur.
- Frame latch: when the index wraps to 0 (and on the first tick after reset), number, dp_mask, blink_mask and lzb_en are captured into shadow registers. All mid-frame input changes become visible at the next frame only; there is no tearing.
- frame_start pulses in the cycle the index wraps to 0.
- Ghost blanking: for the first GHOST_CYCLES cycles of each digit slot (counter value < GHOST_CYCLES), io_sel is all 1 and io_seg is 8'hFF. After that, io_sel has exactly bit index low.
- Blink counter is free-running and independent of the scan. It toggles phase at terminal count. If blink_mask[k]=1 and phase is hidden, digit k shows io_seg=8'hFF with its anode still driven.
- Leading-zero blanking (shadow lzb_en=1): digit k is blanked if it and all higher digits equal 0. Digit 0 is never blanked, so 0000 shows "0". A blanked digit's dp still follows dp_mask.
- Decode is full hex: 0-9 standard, A b C d E F. Examples: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
- io_seg[7] = ~dp_mask[index], masked by blink the same way as the segments.
- Outputs are registered. io_sel and io_seg update one cycle after the index or counter condition that selects them; the 1-cycle latency is uniform.

Test Plan:
- Bench params throughout: NUM_DIGITS=4, CLK_FREQ_HZ=1000, REFRESH_HZ=50, GHOST_CYCLES=1 (CYCLES_PER_DIGIT=5), BLINK_HZ=25 (20-cycle half period).
- Scan/refresh: number=16'h1234, masks 0 -> io_sel cycles 1110,1101,1011,0111 (4 driven cycles, 1 ghost cycle of 1111 each). Segments show 4,3,2,1 with the matching anodes. frame_start has a period of 20 cycles.
- Tear-free latch: change number to 16'h9999 while digit 2 is active -> digits 2 and 3 of the current frame still show 2 and 1. The next frame shows all 9s.
- Leading-zero blanking: number=16'h0050, lzb_en=1 -> digits 3 and 2 give io_seg=FF, digit 1 shows "5", digit 0 shows "0". number=16'h0000 -> only digit 0 shows "0".
- Blink and dp: blink_mask=4'b0001, dp_mask=4'b0100 -> digit 0 alternates "4" and FF every 20 cycles. Digit 2 always has io_seg[7]=0.
- Reset mid-operation: assert rst for 1 cycle mid-slot of digit 2 -> the next cycle io_sel=1111 and io_seg=FF. Scan restarts at digit 0, and the first full digit-0 slot begins 5 cycles later.

Source files
------------

// File: rtl/display_scan_mux.sv
// Multiplexed seven-segment scanner: clock-enable scan, ghost blanking, blink,
// decimal points, leading-zero blanking and frame-latched (tear-free) inputs.
module display_scan_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int REFRESH_HZ   = 500,
   parameter int BLINK_HZ     = 2,
   parameter int GHOST_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] number,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lzb_en,
   output logic [NUM_DIGITS-1:0]   io_sel,
   output logic [7:0]              io_seg,
   output logic                    frame_start
);

   localparam int CYCLES_PER_DIGIT = CLK_FREQ_HZ / REFRESH_HZ / NUM_DIGITS;
   localparam int BLINK_HALF       = CLK_FREQ_HZ / (2 * BLINK_HZ);
   localparam int CNT_W = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
   localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CYCLES_PER_DIGIT - 1);
   localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYCLES);
   localparam logic [BLK_W-1:0] BLK_MAX   = BLK_W'(BLINK_HALF - 1);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        tick_cnt;
   logic [IDX_W-1:0]        scan_idx;
   logic [IDX_W-1:0]        idx_next;
   logic                    primed;
   logic [BLK_W-1:0]        blink_cnt;
   logic                    blink_hidden;
   logic [4*NUM_DIGITS-1:0] num_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blink_sh;
   logic                    lzb_sh;

   logic                    tick;
   logic                    wrap;
   logic [3:0]              digit;
   logic                    dp_bit;
   logic                    blink_bit;
   logic                    lz_blank;
   logic                    all_zero;
   logic [NUM_DIGITS-1:0]   sel_drive;
   logic [6:0]              glyph;
   logic [NUM_DIGITS-1:0]   sel_d;
   logic [7:0]              seg_d;

   // Until the first tick after reset, nothing is latched yet; that tick is treated as a frame wrap.
   always_comb begin
      tick     = (tick_cnt == CNT_MAX);
      wrap     = tick && (!primed || scan_idx == IDX_MAX);
      idx_next = wrap ? '0 : scan_idx + 1'b1;
   end

   // Walk from the top digit down so all_zero means "this digit and every higher one is 0".
   always_comb begin
      digit     = 4'h0;
      dp_bit    = 1'b0;
      blink_bit = 1'b0;
      lz_blank  = 1'b0;
      all_zero  = 1'b1;
      sel_drive = '1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         all_zero = all_zero && (num_sh[4*k +: 4] == 4'h0);
         if (scan_idx == IDX_W'(k)) begin
            digit        = num_sh[4*k +: 4];
            dp_bit       = dp_sh[k];
            blink_bit    = blink_sh[k];
            lz_blank     = lzb_sh && all_zero && (k != 0);
            sel_drive[k] = 1'b0;
         end
      end
   end

   always_comb begin
      case (digit)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   end

   // A blink-hidden digit keeps its anode driven so brightness of neighbours is unaffected.
   always_comb begin
      sel_d = '1;
      seg_d = 8'hFF;
      if (primed && tick_cnt >= GHOST_END) begin
         sel_d = sel_drive;
         if (!(blink_hidden && blink_bit)) begin
            seg_d = {~dp_bit, lz_blank ? 7'h7F : glyph};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt     <= '0;
         scan_idx     <= '0;
         primed       <= 1'b0;
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
         num_sh       <= '0;
         dp_sh        <= '0;
         blink_sh     <= '0;
         lzb_sh       <= 1'b0;
         io_sel       <= '1;
         io_seg       <= 8'hFF;
         frame_start  <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) begin
            scan_idx <= idx_next;
         end
         if (wrap) begin
            primed   <= 1'b1;
            num_sh   <= number;
            dp_sh    <= dp_mask;
            blink_sh <= blink_mask;
            lzb_sh   <= lzb_en;
         end
         if (blink_cnt == BLK_MAX) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         frame_start <= wrap;
         io_sel      <= sel_d;
         io_seg      <= seg_d;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: cycle-count reference model checked every cycle,
// pinned by hand-computed expectations, followed by a randomized soak.
module tb_display_scan_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] number = '0;
   logic [3:0]  dp_mask = '0;
   logic [3:0]  blink_mask = '0;
   logic        lzb_en = 1'b0;
   logic [3:0]  io_sel;
   logic [7:0]  io_seg;
   logic        frame_start;

   int vectors = 0;
   int miscompares = 0;

   display_scan_mux #(
      .NUM_DIGITS(4), .CLK_FREQ_HZ(1000), .REFRESH_HZ(50),
      .BLINK_HZ(25), .GHOST_CYCLES(1)
   ) dut (
      .clk(clk), .rst(rst), .number(number), .dp_mask(dp_mask),
      .blink_mask(blink_mask), .lzb_en(lzb_en), .io_sel(io_sel),
      .io_seg(io_seg), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   logic [6:0] segTab [16];
   initial begin
      segTab[0]  = 7'h40; segTab[1]  = 7'h79; segTab[2]  = 7'h24; segTab[3]  = 7'h30;
      segTab[4]  = 7'h19; segTab[5]  = 7'h12; segTab[6]  = 7'h02; segTab[7]  = 7'h78;
      segTab[8]  = 7'h00; segTab[9]  = 7'h10; segTab[10] = 7'h08; segTab[11] = 7'h03;
      segTab[12] = 7'h46; segTab[13] = 7'h21; segTab[14] = 7'h06; segTab[15] = 7'h0E;
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] num, input logic [3:0] dp,
                                input logic [3:0] blk, input logic lzb);
      number     = num;
      dp_mask    = dp;
      blink_mask = blk;
      lzb_en     = lzb;
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Model state: n = cycles since the last reset edge; the latched frame inputs.
   int          n = 0;
   logic        model_ok = 1'b0;
   logic [15:0] sh_num = '0;
   logic [3:0]  sh_dp = '0;
   logic [3:0]  sh_blink = '0;
   logic        sh_lzb = 1'b0;
   logic [3:0]  exp_sel;
   logic [7:0]  exp_seg;
   logic        exp_fs;

   // Slot s = st/5 (5 cycles each); slot 0 is the pre-latch slot, slot s>=1 shows digit (s-1)%4.
   function automatic void modelOut(input int st, output logic [3:0] sel, output logic [7:0] seg);
      int          idx;
      logic [15:0] shifted;
      logic        hidden;
      logic        blank;
      sel = 4'hF;
      seg = 8'hFF;
      if (st >= 5 && (st % 5) >= 1) begin
         idx      = ((st / 5) - 1) % 4;
         sel[idx] = 1'b0;
         shifted  = sh_num >> (4 * idx);
         hidden   = ((st / 20) % 2) == 1;
         if (!(hidden && sh_blink[idx])) begin
            blank = sh_lzb && (idx != 0) && (shifted == 16'h0);
            seg   = {~sh_dp[idx], blank ? 7'h7F : segTab[shifted[3:0]]};
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         n        = 0;
         model_ok = 1'b1;
         exp_sel  = 4'hF;
         exp_seg  = 8'hFF;
         exp_fs   = 1'b0;
      end else if (model_ok) begin
         modelOut(n, exp_sel, exp_seg);
         n++;
         exp_fs = (n >= 5) && (((n - 5) % 20) == 0);
         if (exp_fs) begin
            sh_num   = number;
            sh_dp    = dp_mask;
            sh_blink = blink_mask;
            sh_lzb   = lzb_en;
         end
      end
      #1;
      if (model_ok) begin
         checkOutput("model io_sel", {4'h0, io_sel}, {4'h0, exp_sel});
         checkOutput("model io_seg", io_seg, exp_seg);
         checkOutput("model frame_start", {7'h0, frame_start}, {7'h0, exp_fs});
      end
   end

   function automatic logic [15:0] randNum();
      logic [15:0] r;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      return r;
   endfunction

   initial begin
      applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      checkOutput("reset io_sel", {4'h0, io_sel}, 8'h0F);
      checkOutput("reset io_seg", io_seg, 8'hFF);
      checkOutput("reset frame_start", {7'h0, frame_start}, 8'h00);
      step(5);
      checkOutput("first frame_start", {7'h0, frame_start}, 8'h01);
      step(2);
      checkOutput("scan d0 sel", {4'h0, io_sel}, 8'h0E);
      checkOutput("scan d0 seg", io_seg, 8'h99);
      step(4);
      checkOutput("ghost sel", {4'h0, io_sel}, 8'h0F);
      checkOutput("ghost seg", io_seg, 8'hFF);
      step(1);
      checkOutput("scan d1 sel", {4'h0, io_sel}, 8'h0D);
      checkOutput("scan d1 seg", io_seg, 8'hB0);

      // Change the word while digit 2 of the current frame is on screen.
      step(25);
      applyStimulus(16'h9999, 4'h0, 4'h0, 1'b0);
      step(2);
      checkOutput("tear d2 sel", {4'h0, io_sel}, 8'h0B);
      checkOutput("tear d2 seg", io_seg, 8'hA4);
      step(5);
      checkOutput("tear d3 seg", io_seg, 8'hF9);
      step(3);
      checkOutput("next frame d0 seg", io_seg, 8'h90);

      applyStimulus(16'h0050, 4'h0, 4'h0, 1'b1);
      step(20);
      checkOutput("lzb d0 seg", io_seg, 8'hC0);
      step(5);
      checkOutput("lzb d1 seg", io_seg, 8'h92);
      step(5);
      checkOutput("lzb d2 sel", {4'h0, io_sel}, 8'h0B);
      checkOutput("lzb d2 seg", io_seg, 8'hFF);
      applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1);
      step(10);
      checkOutput("lzb zero d0 seg", io_seg, 8'hC0);
      step(5);
      checkOutput("lzb zero d1 seg", io_seg, 8'hFF);

      applyStimulus(16'h1234, 4'b0100, 4'b0001, 1'b0);
      step(15);
      checkOutput("blink hidden sel", {4'h0, io_sel}, 8'h0E);
      checkOutput("blink hidden seg", io_seg, 8'hFF);
      step(10);
      checkOutput("dp d2 seg", io_seg, 8'h24);
      step(10);
      checkOutput("blink visible seg", io_seg, 8'h99);

      // One-cycle reset in the middle of digit 2's slot.
      step(10);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      checkOutput("mid reset sel", {4'h0, io_sel}, 8'h0F);
      checkOutput("mid reset seg", io_seg, 8'hFF);
      step(5);
      checkOutput("restart frame_start", {7'h0, frame_start}, 8'h01);
      step(2);
      checkOutput("restart d0 seg", io_seg, 8'h99);

      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            applyStimulus(randNum(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
         end
         rst = ($urandom_range(0, 199) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
